// File: rtl/lsu_ctrl_if.sv
// CPU-side request/response channel and memory-bus channel of the load/store unit.
// slave: the LSU view (takes CPU requests, drives the memory bus).
// master: the environment view (CPU plus memory).
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_op, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_wr, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_wr, req_op, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_wr, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one CPU access at a time, checks
// alignment/op legality, issues a single word-aligned bus request, extracts
// and extends load data, and bounds the read-return wait with a timeout.
// All outputs are registered; one response pulse per accepted request.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [2:0]  op_r;
  logic [1:0]  off_r;
  logic        wr_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;
  logic        mem_valid_r;
  logic        mem_wr_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wmask_r;

  logic        accept_s;
  logic        dec_err_s;

  // Illegal op, store with unsigned op, or misaligned half/word access.
  function automatic logic decode_err(input logic wr, input logic [2:0] op,
                                      input logic [1:0] off);
    logic e;
    case (op)
      3'b000:  e = 1'b0;
      3'b001:  e = off[0];
      3'b010:  e = (off != 2'b00);
      3'b100:  e = wr;
      3'b101:  e = wr | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Byte-lane enables for a legal store.
  function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] m;
    case (op[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Shift the addressed field down and sign/zero-extend by op.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] data);
    logic [31:0] s;
    logic [31:0] r;
    s = data >> {off, 3'b000};
    case (op)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b010:  r = s;
      3'b100:  r = {24'd0, s[7:0]};
      3'b101:  r = {16'd0, s[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign accept_s  = bus.req_valid & req_ready_r;
  assign dec_err_s = decode_err(bus.req_wr, bus.req_op, bus.req_addr[1:0]);

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      op_r         <= 3'd0;
      off_r        <= 2'd0;
      wr_r         <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      mem_valid_r  <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      mem_wmask_r  <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r        <= bus.req_op;
            off_r       <= bus.req_addr[1:0];
            wr_r        <= bus.req_wr;
            req_ready_r <= 1'b0;
            if (dec_err_s) begin
              // Rejected without touching the bus.
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'd0;
            end else begin
              state_r     <= ADDR;
              mem_valid_r <= 1'b1;
              mem_wr_r    <= bus.req_wr;
              mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
              if (bus.req_wr) begin
                mem_wdata_r <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
                mem_wmask_r <= store_mask(bus.req_op, bus.req_addr[1:0]);
              end else begin
                mem_wdata_r <= 32'd0;
                mem_wmask_r <= 4'b0000;
              end
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ADDR: begin
          // Request fields stay frozen until the bus takes them.
          if (bus.mem_ready) begin
            mem_valid_r <= 1'b0;
            if (wr_r) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b0;
              resp_rdata_r <= 32'd0;
            end else begin
              state_r <= WAIT;
              cnt_r   <= 8'd0;
            end
          end else begin
            state_r <= ADDR;
          end
        end
        WAIT: begin
          // Read return beats the timeout when both land on the same cycle.
          if (bus.mem_rvalid) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= load_extract(op_r, off_r, bus.mem_rdata);
          end else if (cnt_r + 8'd1 == TIMEOUT_C) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          mem_valid_r  <= 1'b0;
          req_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.mem_valid  = mem_valid_r;
  assign bus.mem_wr     = mem_wr_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_wmask  = mem_wmask_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of single accesses plus
// hand-written sequences for stall, timeout, late return and reset abandon.
module tb_lsu_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lsu_ctrl_if bus();

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        dec_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
  } vec_t;

  vec_t vecs[15];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    chk1({p, "_ready_idle"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_wr    = v.wr;
    bus.req_op    = v.op;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    step();
    bus.req_valid = 1'b0;
    chk1({p, "_ready_busy"}, bus.req_ready, 1'b0);
    if (v.dec_err) begin
      chk1({p, "_mem_valid"}, bus.mem_valid, 1'b0);
      chk1({p, "_resp_valid"}, bus.resp_valid, 1'b1);
      chk1({p, "_resp_err"}, bus.resp_err, 1'b1);
      chk32({p, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    end else begin
      chk1({p, "_mem_valid"}, bus.mem_valid, 1'b1);
      chk1({p, "_resp_early"}, bus.resp_valid, 1'b0);
      chk1({p, "_mem_wr"}, bus.mem_wr, v.wr);
      chk32({p, "_mem_addr"}, bus.mem_addr, v.exp_maddr);
      chk32({p, "_mem_wmask"}, {28'd0, bus.mem_wmask}, {28'd0, v.exp_wmask});
      if (v.wr) begin
        chk32({p, "_mem_wdata"}, bus.mem_wdata, v.exp_wdata);
      end
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk1({p, "_mem_valid_drop"}, bus.mem_valid, 1'b0);
      if (v.wr) begin
        chk1({p, "_resp_valid"}, bus.resp_valid, 1'b1);
        chk1({p, "_resp_err"}, bus.resp_err, 1'b0);
        chk32({p, "_resp_rdata"}, bus.resp_rdata, 32'd0);
      end else begin
        chk1({p, "_resp_wait"}, bus.resp_valid, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.rdata;
        step();
        bus.mem_rvalid = 1'b0;
        chk1({p, "_resp_valid"}, bus.resp_valid, 1'b1);
        chk1({p, "_resp_err"}, bus.resp_err, 1'b0);
        chk32({p, "_resp_rdata"}, bus.resp_rdata, v.exp_rdata);
      end
      chk1({p, "_ready_resp"}, bus.req_ready, 1'b0);
    end
    step();
    chk1({p, "_resp_pulse"}, bus.resp_valid, 1'b0);
    chk1({p, "_ready_back"}, bus.req_ready, 1'b1);
    chk32({p, "_rdata_hold"}, bus.resp_rdata, v.exp_rdata);
    chk1({p, "_err_hold"}, bus.resp_err, v.dec_err);
  endtask

  // Word load accepted and handshaken; leaves the bench in the first WAIT cycle.
  task automatic start_load(input logic [31:0] addr, input logic rvalid_in_addr);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_op    = 3'b010;
    bus.req_addr  = addr;
    step();
    bus.req_valid  = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = rvalid_in_addr;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    step();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //           wr    op      addr          wdata         rdata         derr  exp_rdata     exp_maddr     exp_wdata     mask
    vecs[0]  = '{1'b0, 3'b000, 32'h8000_0003, 32'h0000_0000, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 32'h8000_0000, 32'h0000_0000, 4'b0000};
    vecs[1]  = '{1'b1, 3'b001, 32'h8000_0102, 32'h0000_ABCD, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h8000_0100, 32'hABCD_0000, 4'b1100};
    vecs[2]  = '{1'b0, 3'b101, 32'h8000_0002, 32'h0000_0000, 32'h8001_0000, 1'b0, 32'h0000_8001, 32'h8000_0000, 32'h0000_0000, 4'b0000};
    vecs[3]  = '{1'b0, 3'b010, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0010, 32'h0000_0000, 32'h1234_8765, 1'b0, 32'hFFFF_8765, 32'h0000_0010, 32'h0000_0000, 4'b0000};
    vecs[5]  = '{1'b0, 3'b100, 32'h0000_0021, 32'h0000_0000, 32'h0000_F000, 1'b0, 32'h0000_00F0, 32'h0000_0020, 32'h0000_0000, 4'b0000};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_0043, 32'h0000_005A, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0040, 32'h5A00_0000, 4'b1000};
    vecs[7]  = '{1'b1, 3'b010, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0044, 32'hDEAD_BEEF, 4'b1111};
    vecs[8]  = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_0011, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    vecs[9]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    vecs[10] = '{1'b0, 3'b001, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    vecs[12] = '{1'b0, 3'b110, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    vecs[13] = '{1'b0, 3'b111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    vecs[14] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 32'h0000_0100, 32'h0000_0000, 4'b0000};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_mem_valid", bus.mem_valid, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk1("rst_resp_err", bus.resp_err, 1'b0);
    chk32("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk1("rst_mem_wr", bus.mem_wr, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'd0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk32("rst_mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], i);
    end

    // Timeout: four silent WAIT cycles end in an error response
    start_load(32'h0000_0200, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("to_wait%0d", i), bus.resp_valid, 1'b0);
      step();
    end
    chk1("to_resp_valid", bus.resp_valid, 1'b1);
    chk1("to_resp_err", bus.resp_err, 1'b1);
    chk32("to_resp_rdata", bus.resp_rdata, 32'd0);
    step();
    chk1("to_resp_pulse", bus.resp_valid, 1'b0);

    // Return on the last allowed WAIT cycle wins; rvalid during ADDR is ignored
    start_load(32'h0000_0300, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("late_wait%0d", i), bus.resp_valid, 1'b0);
      step();
    end
    chk1("late_wait3", bus.resp_valid, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_3344;
    step();
    bus.mem_rvalid = 1'b0;
    chk1("late_resp_valid", bus.resp_valid, 1'b1);
    chk1("late_resp_err", bus.resp_err, 1'b0);
    chk32("late_resp_rdata", bus.resp_rdata, 32'h1122_3344);
    step();

    // Bus stall: request fields frozen over six ADDR cycles
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_op    = 3'b000;
    bus.req_addr  = 32'h0000_0011;
    bus.req_wdata = 32'h0000_0077;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk1($sformatf("stall%0d_mem_valid", i), bus.mem_valid, 1'b1);
      chk32($sformatf("stall%0d_mem_addr", i), bus.mem_addr, 32'h0000_0010);
      chk32($sformatf("stall%0d_mem_wdata", i), bus.mem_wdata, 32'h0000_7700);
      chk32($sformatf("stall%0d_mem_wmask", i), {28'd0, bus.mem_wmask}, 32'h0000_0002);
      chk1($sformatf("stall%0d_resp", i), bus.resp_valid, 1'b0);
      if (i == 5) begin
        bus.mem_ready = 1'b1;
      end
      step();
    end
    bus.mem_ready = 1'b0;
    chk1("stall_resp_valid", bus.resp_valid, 1'b1);
    chk1("stall_mem_valid", bus.mem_valid, 1'b0);
    step();

    // Reset during WAIT abandons the load; the stale return is ignored
    start_load(32'h0000_0400, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rw_ready_in_rst", bus.req_ready, 1'b0);
    chk1("rw_mem_valid", bus.mem_valid, 1'b0);
    chk1("rw_resp_valid0", bus.resp_valid, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    step();
    bus.mem_rvalid = 1'b0;
    chk1("rw_resp_valid1", bus.resp_valid, 1'b0);
    chk1("rw_ready_after", bus.req_ready, 1'b1);
    chk32("rw_resp_rdata", bus.resp_rdata, 32'd0);
    step();
    chk1("rw_resp_valid2", bus.resp_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
